// File: rtl/ex_div_ctrl_pkg.sv
// Shared divider definitions: FSM state encodings, result/handshake levels and sizing.
// A sign fix-up helper is used only when DIV_SIGNED_EN is defined.
package ex_div_ctrl_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 6;

  localparam logic RST_ENABLE           = 1'b1;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Step 32 is the final shift-subtract; its edge also publishes the result.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(REG_W - 1);

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic [REG_W-1:0] cond_negate(input logic neg, input logic [REG_W-1:0] value);
    return neg ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/ex_div_ctrl_if.sv
// EX-stage <-> divider handshake: start/annul request with operands, registered result back.
interface ex_div_ctrl_if;
  import ex_div_ctrl_pkg::*;

  logic             start_i;
  logic             annul_i;
  logic             signed_div_i;
  logic [REG_W-1:0] opdata1_i;
  logic [REG_W-1:0] opdata2_i;
  logic [63:0]      result_o;
  logic             ready_o;
  logic             busy_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// One restoring division step on the 65-bit working value {remainder[64:32], dividend/quotient[31:0]}.
module div_step
  import ex_div_ctrl_pkg::*;
(
  input  logic [64:0]      work,
  input  logic [REG_W-1:0] divisor,
  output logic [64:0]      work_next
);
  logic [32:0] rem_shift;
  logic [33:0] diff;
  logic        unused_msb;

  // Partial remainder is always below the divisor, so bit 64 never carries information.
  assign unused_msb = work[64];
  assign rem_shift  = work[63:31];
  assign diff       = {1'b0, rem_shift} - {2'b00, divisor};

  always_comb begin
    if (diff[33]) begin
      work_next = {rem_shift, work[30:0], 1'b0};
    end else begin
      work_next = {diff[32:0], work[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divider controller for the EX stage: FSM, step counter, sign fix-up.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every divide is unsigned.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  ex_div_ctrl_if.slave bus
);
  div_state_e       state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [64:0]      work, work_n, work_step;
  logic [REG_W-1:0] divisor, divisor_n;
  logic [63:0]      result, result_n;
  logic             ready, ready_n;
  logic [REG_W-1:0] dividend_mag, divisor_mag;
  logic [63:0]      step_result;

`ifdef DIV_SIGNED_EN
  logic neg_quot, neg_quot_n, neg_rem, neg_rem_n;
  logic op1_neg, op2_neg;

  // Magnitudes are taken at acceptance; the sign flags travel with the divide.
  assign op1_neg      = bus.signed_div_i & bus.opdata1_i[REG_W-1];
  assign op2_neg      = bus.signed_div_i & bus.opdata2_i[REG_W-1];
  assign dividend_mag = cond_negate(op1_neg, bus.opdata1_i);
  assign divisor_mag  = cond_negate(op2_neg, bus.opdata2_i);
  assign step_result  = {cond_negate(neg_rem, work_step[63:32]),
                         cond_negate(neg_quot, work_step[31:0])};
`else
  logic unused_signed;

  assign unused_signed = bus.signed_div_i;
  assign dividend_mag  = bus.opdata1_i;
  assign divisor_mag   = bus.opdata2_i;
  assign step_result   = work_step[63:0];
`endif

  div_step u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_step)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst == RST_ENABLE) begin
      state   <= DIV_FREE;
      count   <= '0;
      work    <= '0;
      divisor <= '0;
      result  <= '0;
      ready   <= DIV_RESULT_NOT_READY;
`ifdef DIV_SIGNED_EN
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      count   <= count_n;
      work    <= work_n;
      divisor <= divisor_n;
      result  <= result_n;
      ready   <= ready_n;
`ifdef DIV_SIGNED_EN
      neg_quot <= neg_quot_n;
      neg_rem  <= neg_rem_n;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_n   = state;
    count_n   = count;
    work_n    = work;
    divisor_n = divisor;
    result_n  = result;
    ready_n   = ready;
`ifdef DIV_SIGNED_EN
    neg_quot_n = neg_quot;
    neg_rem_n  = neg_rem;
`endif
    unique case (state)
      DIV_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          state_n   = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
          count_n   = '0;
          work_n    = {33'd0, dividend_mag};
          divisor_n = divisor_mag;
`ifdef DIV_SIGNED_EN
          neg_quot_n = op1_neg ^ op2_neg;
          neg_rem_n  = op1_neg;
`endif
        end
      end
      DIV_BYZERO: begin
        if (bus.annul_i) begin
          state_n = DIV_FREE;
        end else begin
          state_n = DIV_END;
          ready_n = DIV_RESULT_READY;
        end
        result_n = '0;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_n  = DIV_FREE;
          count_n  = '0;
          work_n   = '0;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end else begin
          work_n  = work_step;
          count_n = count + 1'b1;
          if (count == LAST_STEP) begin
            state_n  = DIV_END;
            result_n = step_result;
            ready_n  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (rst != RST_ENABLE) &&
                        (((state == DIV_FREE) && (bus.start_i == DIV_START) && !bus.annul_i) ||
                         (state == DIV_BYZERO) || (state == DIV_ON));
endmodule
